washer_plant_responder: RTL and testbench
=========================================

// Module: washer_plant_responder
// PURPOSE
//  Plant-side counterpart of the washing-machine controller: consumes its actuator commands
//  (valves, motor, wash mode, lock, done) and produces the sensor/timer events it waits on
//  (filled, drained, detergent_added, cycle_timeout, spin_timeout). Closes the loop so the
//  controller runs unattended in simulation and on-board demos; replaces hand-timed stimulus.
// PARAMETERS
//  LEVEL_MAX    8   water-level count at which the tank is full (>=1)
//  DOSE_CYCLES  2   cycles of soap_wash with tank full before detergent_added (>=1)
//  WASH_CYCLES  16  agitate-phase cycles before cycle_timeout (>=1)
//  SPIN_CYCLES  12  spin-phase cycles before spin_timeout (>=1)
// PORTS
//  clk              in   1  system clock, rising edge
//  reset_n          in   1  asynchronous, active-low reset
//  fill_value_on    in   1  fill valve command
//  drain_value_on   in   1  drain valve command
//  motor_on         in   1  drum motor command
//  soap_wash        in   1  controller in soap-wash mode
//  water_wash       in   1  controller in rinse mode
//  door_lock        in   1  door locked
//  done             in   1  cycle-complete indication
//  filled           out  1  level == LEVEL_MAX
//  drained          out  1  level == 0
//  detergent_added  out  1  detergent dosed (sticky)
//  cycle_timeout    out  1  agitate timer expired (held)
//  spin_timeout     out  1  spin timer expired (held)
//  water_level      out  LW level count, LW = $clog2(LEVEL_MAX+1)
//  door_fault       out  1  !door_lock while water_level != 0
// BEHAVIOUR
//  Reset: water_level=0, drained=1, filled=0, detergent_added=0, cycle_timeout=0,
//   spin_timeout=0, door_fault=0 (door_lock ignored during reset), phase=OFF, timers=0.
//  All outputs decode from registered state; no extra output flops; changes one edge after cause.
//  Level: fill only -> +1/cycle, saturate at LEVEL_MAX; drain only -> -1/cycle, saturate at 0;
//   both or neither -> hold. No wrap in either direction.
//  Dose counter: counts while soap_wash && filled; at DOSE_CYCLES sets detergent_added.
//   Counter clears when soap_wash low (before dose done). detergent_added clears on done=1 or
//   door_lock=0; done has priority over a same-cycle set.
//  Motor phase FSM (states OFF, AGITATE, SPIN), timer width TW = $clog2(max(WASH,SPIN)+1):
//   OFF -> AGITATE: motor_on && !drain_value_on; OFF -> SPIN: motor_on && drain_value_on.
//   AGITATE -> SPIN: drain_value_on rises while motor_on; timer restarts at 0, cycle_timeout clears.
//   SPIN -> AGITATE: drain_value_on falls while motor_on; timer restarts, spin_timeout clears.
//   any -> OFF: motor_on=0; timer and both timeouts clear same edge.
//   Timer increments each cycle in AGITATE/SPIN, saturates at its limit; cycle_timeout=1 in
//   AGITATE when timer==WASH_CYCLES; spin_timeout=1 in SPIN when timer==SPIN_CYCLES.
//   First counted cycle is the entry edge: timeout visible WASH_CYCLES+1 edges after motor_on.
//  water_wash: informational only; agitation timing identical to soap_wash.
//  door_fault: combinational on door_lock and registered level; no effect on other state.
//  Reset mid-cycle: all state returns to reset values immediately (async), tank empty.
// STRUCTURE
//  Shared package wm_pkg: phase enum {PH_OFF, PH_AGITATE, PH_SPIN}, default parameter constants.
//  One sub-module: wm_phase_timer (clear/enable/limit inputs, saturating count, expired flag),
//   used for the motor phase timer; level and dose logic stay inline.
// TESTING
//  1 reset_n=0 with all inputs 1 -> all outputs at reset values, drained=1, water_level=0.
//  2 fill_value_on=1 8 cycles -> water_level 1..8, filled=1 at 8th edge, holds at 8 on more fill.
//  3 filled, soap_wash=1 -> detergent_added=1 after 2 edges; done pulse -> clears next edge.
//  4 motor_on=1, drain=0 -> cycle_timeout=1 at 17th edge; motor_on=0 -> clears next edge.
//  5 level 8, drain_value_on=1 with motor_on -> level 8..0, drained at 8th edge; spin_timeout at
//    13th edge; level never below 0.
//  6 level 3, door_lock=0 -> door_fault=1; fill+drain together -> level holds 3.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared types and default constants for the washing-machine plant model.
package wm_pkg;

  typedef enum logic [1:0] {
    PH_OFF     = 2'd0,
    PH_AGITATE = 2'd1,
    PH_SPIN    = 2'd2
  } phase_t;

  localparam int unsigned DEF_LEVEL_MAX   = 8;
  localparam int unsigned DEF_DOSE_CYCLES = 2;
  localparam int unsigned DEF_WASH_CYCLES = 16;
  localparam int unsigned DEF_SPIN_CYCLES = 12;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Saturating phase timer: clears to zero, counts up to limit, flags when it gets there.
module wm_phase_timer #(
  parameter int unsigned TW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW-1:0] limit,
  output logic          expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/washer_plant_responder.sv
// Plant model closing the loop around the washing-machine controller: tank level,
// detergent dosing and motor phase timers, all decoded from registered state.
module washer_plant_responder
  import wm_pkg::*;
#(
  parameter int unsigned LEVEL_MAX   = DEF_LEVEL_MAX,
  parameter int unsigned DOSE_CYCLES = DEF_DOSE_CYCLES,
  parameter int unsigned WASH_CYCLES = DEF_WASH_CYCLES,
  parameter int unsigned SPIN_CYCLES = DEF_SPIN_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           fill_value_on,
  input  logic                           drain_value_on,
  input  logic                           motor_on,
  input  logic                           soap_wash,
  input  logic                           water_wash,
  input  logic                           door_lock,
  input  logic                           done,
  output logic                           filled,
  output logic                           drained,
  output logic                           detergent_added,
  output logic                           cycle_timeout,
  output logic                           spin_timeout,
  output logic [$clog2(LEVEL_MAX+1)-1:0] water_level,
  output logic                           door_fault
);

  localparam int unsigned LW = $clog2(LEVEL_MAX + 1);
  localparam int unsigned DW = $clog2(DOSE_CYCLES + 1);
  localparam int unsigned TW = $clog2(max_u(WASH_CYCLES, SPIN_CYCLES) + 1);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(LEVEL_MAX);
  localparam logic [DW-1:0] DOSE_LAST  = DW'(DOSE_CYCLES - 1);

  logic [LW-1:0] level;
  logic [DW-1:0] dose_cnt;
  logic          dose_done;
  logic          dose_clear;
  phase_t        phase, phase_nxt;
  logic          timer_clear;
  logic          timer_enable;
  logic [TW-1:0] timer_limit;
  logic          timer_expired;

  // Rinse mode times exactly like soap mode, so it has no effect here.
  logic unused_water_wash;
  assign unused_water_wash = water_wash;

  // Tank level: saturating up/down counter; both valves open cancels out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else if (fill_value_on && !drain_value_on && (level != LEVEL_FULL)) begin
      level <= level + 1'b1;
    end else if (drain_value_on && !fill_value_on && (level != '0)) begin
      level <= level - 1'b1;
    end
  end

  assign filled      = (level == LEVEL_FULL);
  assign drained     = (level == '0);
  assign water_level = level;
  assign door_fault  = !door_lock && (level != '0);

  // A clear outranks a same-cycle dose completion.
  assign dose_clear = done || !door_lock;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dose_cnt  <= '0;
      dose_done <= 1'b0;
    end else if (dose_clear) begin
      dose_cnt  <= '0;
      dose_done <= 1'b0;
    end else if (!soap_wash) begin
      dose_cnt <= '0;
    end else if (filled && !dose_done) begin
      if (dose_cnt == DOSE_LAST) begin
        dose_cnt  <= '0;
        dose_done <= 1'b1;
      end else begin
        dose_cnt <= dose_cnt + 1'b1;
      end
    end
  end

  assign detergent_added = dose_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= PH_OFF;
    end else begin
      phase <= phase_nxt;
    end
  end

  // Staying in AGITATE with drain open would mean drain rose, so level tests suffice.
  always_comb begin
    phase_nxt = phase;
    if (!motor_on) begin
      phase_nxt = PH_OFF;
    end else begin
      unique case (phase)
        PH_OFF:     phase_nxt = drain_value_on ? PH_SPIN : PH_AGITATE;
        PH_AGITATE: if (drain_value_on)  phase_nxt = PH_SPIN;
        PH_SPIN:    if (!drain_value_on) phase_nxt = PH_AGITATE;
        default:    phase_nxt = PH_OFF;
      endcase
    end
  end

  always_comb begin
    timer_clear   = (phase_nxt != phase) || (phase_nxt == PH_OFF);
    timer_enable  = (phase != PH_OFF);
    timer_limit   = (phase == PH_SPIN) ? TW'(SPIN_CYCLES) : TW'(WASH_CYCLES);
    cycle_timeout = (phase == PH_AGITATE) && timer_expired;
    spin_timeout  = (phase == PH_SPIN) && timer_expired;
  end

  wm_phase_timer #(
    .TW(TW)
  ) u_phase_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .limit   (timer_limit),
    .expired (timer_expired)
  );

endmodule

// File: tb/tb_washer_plant_responder.sv
// Bench for washer_plant_responder: directed scenarios plus random stimulus vs. a cycle model.
module tb_washer_plant_responder;

  localparam int LMAX = 8;
  localparam int DOSE = 2;
  localparam int WASH = 16;
  localparam int SPIN = 12;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fill_value_on, drain_value_on, motor_on, soap_wash, water_wash, door_lock, done;
  logic       filled, drained, detergent_added, cycle_timeout, spin_timeout, door_fault;
  logic [3:0] water_level;

  int vectors     = 0;
  int miscompares = 0;

  // Model: mode 0=off 1=agitate 2=spin, follows motor/drain directly; el = cycles since entry.
  int m_level, m_dose, m_mode, m_el;
  bit m_det;

  always #5 clk = ~clk;

  washer_plant_responder #(
    .LEVEL_MAX   (LMAX),
    .DOSE_CYCLES (DOSE),
    .WASH_CYCLES (WASH),
    .SPIN_CYCLES (SPIN)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fill_value_on   (fill_value_on),
    .drain_value_on  (drain_value_on),
    .motor_on        (motor_on),
    .soap_wash       (soap_wash),
    .water_wash      (water_wash),
    .door_lock       (door_lock),
    .done            (done),
    .filled          (filled),
    .drained         (drained),
    .detergent_added (detergent_added),
    .cycle_timeout   (cycle_timeout),
    .spin_timeout    (spin_timeout),
    .water_level     (water_level),
    .door_fault      (door_fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_dose = 0; m_mode = 0; m_el = 0; m_det = 0;
  endtask

  task automatic model_edge();
    bit was_full;
    int new_mode;
    was_full = (m_level == LMAX);
    if (fill_value_on && !drain_value_on)      m_level = (m_level < LMAX) ? m_level + 1 : LMAX;
    else if (drain_value_on && !fill_value_on) m_level = (m_level > 0) ? m_level - 1 : 0;
    if (done || !door_lock) begin
      m_det = 0; m_dose = 0;
    end else if (!soap_wash) begin
      m_dose = 0;
    end else if (was_full && !m_det) begin
      m_dose++;
      if (m_dose == DOSE) begin m_det = 1; m_dose = 0; end
    end
    new_mode = !motor_on ? 0 : (drain_value_on ? 2 : 1);
    if (new_mode != m_mode || new_mode == 0) m_el = 0;
    else m_el++;
    m_mode = new_mode;
  endtask

  task automatic check_all();
    check_eq("water_level", 32'(water_level), 32'(m_level));
    check_eq("filled", 32'(filled), 32'(m_level == LMAX));
    check_eq("drained", 32'(drained), 32'(m_level == 0));
    check_eq("detergent_added", 32'(detergent_added), 32'(m_det));
    check_eq("cycle_timeout", 32'(cycle_timeout), 32'(m_mode == 1 && m_el >= WASH));
    check_eq("spin_timeout", 32'(spin_timeout), 32'(m_mode == 2 && m_el >= SPIN));
    check_eq("door_fault", 32'(door_fault), 32'(!door_lock && m_level != 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    reset_n = 1'b0;
    {fill_value_on, drain_value_on, motor_on, soap_wash, water_wash, door_lock, done} = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    check_eq("rst_drained", 32'(drained), 32'd1);
    check_eq("rst_level", 32'(water_level), 32'd0);
    door_lock = 1'b0;
    #1;
    check_eq("rst_door_fault", 32'(door_fault), 32'd0);

    {fill_value_on, drain_value_on, motor_on, soap_wash, water_wash, done} = '0;
    door_lock = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // Fill to the top and keep filling.
    fill_value_on = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k <= LMAX) check_eq("fill_level", 32'(water_level), 32'(k));
      else           check_eq("fill_hold", 32'(water_level), 32'(LMAX));
      if (k == LMAX - 1) check_eq("fill_not_full", 32'(filled), 32'd0);
      if (k == LMAX)     check_eq("fill_full", 32'(filled), 32'd1);
    end
    fill_value_on = 1'b0;

    // Dosing, then done clears it.
    soap_wash = 1'b1;
    step(); check_eq("dose_1", 32'(detergent_added), 32'd0);
    step(); check_eq("dose_2", 32'(detergent_added), 32'd1);
    done = 1'b1;
    step(); check_eq("dose_done_clr", 32'(detergent_added), 32'd0);
    done = 1'b0;
    soap_wash = 1'b0;
    step();

    // Agitate timeout.
    motor_on = 1'b1;
    for (int k = 1; k <= WASH + 1; k++) begin
      step();
      if (k == WASH)     check_eq("agit_pre", 32'(cycle_timeout), 32'd0);
      if (k == WASH + 1) check_eq("agit_to", 32'(cycle_timeout), 32'd1);
    end
    motor_on = 1'b0;
    step(); check_eq("agit_off", 32'(cycle_timeout), 32'd0);

    // Drain while spinning.
    motor_on = 1'b1;
    drain_value_on = 1'b1;
    for (int k = 1; k <= SPIN + 2; k++) begin
      step();
      if (k <= LMAX) check_eq("drain_level", 32'(water_level), 32'(LMAX - k));
      if (k == LMAX) check_eq("drain_empty", 32'(drained), 32'd1);
      if (k == SPIN)     check_eq("spin_pre", 32'(spin_timeout), 32'd0);
      if (k == SPIN + 1) check_eq("spin_to", 32'(spin_timeout), 32'd1);
      if (k > LMAX)  check_eq("drain_floor", 32'(water_level), 32'd0);
    end
    motor_on = 1'b0;
    drain_value_on = 1'b0;
    step(); check_eq("spin_off", 32'(spin_timeout), 32'd0);

    // Door fault with water in tank; both valves hold level.
    fill_value_on = 1'b1;
    repeat (3) step();
    fill_value_on = 1'b0;
    door_lock = 1'b0;
    #1;
    check_eq("door_fault_on", 32'(door_fault), 32'd1);
    fill_value_on = 1'b1;
    drain_value_on = 1'b1;
    repeat (3) step();
    check_eq("both_hold", 32'(water_level), 32'd3);
    door_lock = 1'b1;
    #1;
    check_eq("door_fault_off", 32'(door_fault), 32'd0);
    fill_value_on = 1'b0;
    drain_value_on = 1'b0;

    // Random closed-loop-ish stimulus with occasional async reset.
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(0, 15) == 0) begin
        fill_value_on  = 1'($urandom_range(0, 1));
        drain_value_on = 1'($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 19) == 0) drain_value_on = ~drain_value_on;
      if ($urandom_range(0, 29) == 0) motor_on = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        soap_wash  = 1'($urandom_range(0, 1));
        water_wash = ~soap_wash & 1'($urandom_range(0, 1));
      end
      done      = ($urandom_range(0, 39) == 0);
      door_lock = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        #1 reset_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
